// File: rtl/seq_pkg.sv
// Shared types and constants for the command sequencer: FSM state encoding,
// error-cause codes and the default acknowledge byte.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_SEND      = 3'd2,
        S_WAIT_SENT = 3'd3,
        S_WAIT_RESP = 3'd4,
        S_CHECK     = 3'd5,
        S_FINISH    = 3'd6,
        S_ERR       = 3'd7
    } seq_state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_TMO   = 2'b01;
    localparam logic [1:0] ERR_RESP  = 2'b10;
    localparam logic [1:0] ERR_ABORT = 2'b11;

    localparam logic [7:0] RESP_OK_DEFAULT = 8'hA5;

endpackage

// File: rtl/cmd_fifo.sv
// Circular command buffer with registered full/empty flags and an occupancy count.
// A flush discards all entries (and any push in the same cycle).
module cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wptr_r;
    logic [AW-1:0]    rptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push/pop against the flags and compute the next occupancy.
    always_comb begin
        push_ok_s = push && !full_r && !flush;
        pop_ok_s  = pop && !empty_r && !flush;
        if (flush) begin
            count_next_s = {CW{1'b0}};
        end else if (push_ok_s && !pop_ok_s) begin
            count_next_s = count_r + CW'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointers, count and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + AW'(1);
            end
            if (flush) begin
                rptr_r <= wptr_r;
            end else if (pop_ok_s) begin
                rptr_r <= rptr_r + AW'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CW'(DEPTH));
            empty_r <= (count_next_s == {CW{1'b0}});
        end
    end

    // Storage array; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wptr_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rptr_r];
    assign full    = full_r;
    assign empty   = empty_r;
    assign count   = count_r;

endmodule

// File: rtl/cmd_sequencer.sv
// Plays queued 16-bit commands over the RemoteComm send_cmd/cmd_sent handshake,
// checks each acknowledge byte and reports timeout, bad response or abort.
module cmd_sequencer
    import seq_pkg::*;
#(
    parameter int         DEPTH   = 8,
    parameter int         TMO_W   = 24,
    parameter logic [7:0] RESP_OK = RESP_OK_DEFAULT,
    localparam int        NW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [15:0]   push_cmd,
    output logic          full,
    input  logic          start,
    input  logic          abort,
    output logic [15:0]   cmd,
    output logic          send_cmd,
    input  logic          cmd_sent,
    input  logic          resp_rdy,
    input  logic [7:0]    resp,
    output logic          clr_rx_rdy,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [NW-1:0] n_done
);

    seq_state_t       state_r;
    seq_state_t       base_next_s;
    seq_state_t       next_state_s;
    logic [1:0]       base_cause_s;
    logic [1:0]       cause_s;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [TMO_W-1:0] tmo_inc_s;
    logic             tmo_s;
    logic             wait_s;
    logic             resp_ok_s;
    logic             fifo_has_s;
    logic             fifo_empty_s;
    logic [NW-1:0]    fifo_count_s;
    logic [15:0]      head_s;
    logic [7:0]       resp_r;
    logic [15:0]      cmd_r;
    logic             send_cmd_r;
    logic             clr_rx_rdy_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [1:0]       err_code_r;
    logic [NW-1:0]    n_done_r;

    cmd_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (push_cmd),
        .pop     (state_r == S_LOAD),
        .flush   (state_r == S_ERR),
        .rd_data (head_s),
        .full    (full),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    assign fifo_has_s = (fifo_count_s != {NW{1'b0}});
    assign wait_s     = (state_r == S_WAIT_SENT) || (state_r == S_WAIT_RESP);
    assign tmo_inc_s  = tmo_cnt_r + TMO_W'(1);
    assign tmo_s      = (tmo_inc_s == {TMO_W{1'b1}});
    assign resp_ok_s  = (resp_r == RESP_OK);

    // Next-state decode; abort overrides every other event outside IDLE/ERR.
    always_comb begin
        base_next_s  = state_r;
        base_cause_s = ERR_NONE;
        case (state_r)
            S_IDLE: begin
                if (start && fifo_has_s) begin
                    base_next_s = S_LOAD;
                end else begin
                    base_next_s = S_IDLE;
                end
            end
            S_LOAD:  base_next_s = S_SEND;
            S_SEND:  base_next_s = S_WAIT_SENT;
            S_WAIT_SENT: begin
                if (cmd_sent) begin
                    base_next_s = S_WAIT_RESP;
                end else if (tmo_s) begin
                    base_next_s  = S_ERR;
                    base_cause_s = ERR_TMO;
                end else begin
                    base_next_s = S_WAIT_SENT;
                end
            end
            S_WAIT_RESP: begin
                if (resp_rdy) begin
                    base_next_s = S_CHECK;
                end else if (tmo_s) begin
                    base_next_s  = S_ERR;
                    base_cause_s = ERR_TMO;
                end else begin
                    base_next_s = S_WAIT_RESP;
                end
            end
            S_CHECK: begin
                if (!resp_ok_s) begin
                    base_next_s  = S_ERR;
                    base_cause_s = ERR_RESP;
                end else if (fifo_empty_s) begin
                    base_next_s = S_FINISH;
                end else begin
                    base_next_s = S_LOAD;
                end
            end
            S_FINISH: base_next_s = S_IDLE;
            S_ERR:    base_next_s = S_IDLE;
            default:  base_next_s = S_IDLE;
        endcase
        if (abort && (state_r != S_IDLE) && (state_r != S_ERR)) begin
            next_state_s = S_ERR;
            cause_s      = ERR_ABORT;
        end else begin
            next_state_s = base_next_s;
            cause_s      = base_cause_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered outputs, timeout counter, latched response and progress count.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r    <= {TMO_W{1'b0}};
            resp_r       <= 8'h00;
            cmd_r        <= 16'h0000;
            send_cmd_r   <= 1'b0;
            clr_rx_rdy_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            err_code_r   <= ERR_NONE;
            n_done_r     <= {NW{1'b0}};
        end else begin
            if ((next_state_s != state_r) || !wait_s) begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end else begin
                tmo_cnt_r <= tmo_inc_s;
            end
            send_cmd_r   <= (next_state_s == S_SEND);
            clr_rx_rdy_r <= (next_state_s == S_CHECK);
            busy_r       <= (next_state_s != S_IDLE);
            done_r       <= ((state_r == S_FINISH) && (next_state_s == S_IDLE)) ||
                            ((state_r == S_IDLE) && start && !fifo_has_s);
            if (state_r == S_LOAD) begin
                cmd_r <= head_s;
            end
            if ((state_r == S_WAIT_RESP) && resp_rdy) begin
                resp_r <= resp;
            end
            if ((state_r == S_IDLE) && start) begin
                n_done_r <= {NW{1'b0}};
            end else if ((state_r == S_CHECK) && (next_state_s != S_ERR)) begin
                n_done_r <= n_done_r + NW'(1);
            end
            // Error flag is sticky until the next start that actually plays commands.
            if ((state_r == S_IDLE) && start && fifo_has_s) begin
                err_r      <= 1'b0;
                err_code_r <= ERR_NONE;
            end else if ((next_state_s == S_ERR) && (state_r != S_ERR)) begin
                err_r      <= 1'b1;
                err_code_r <= cause_s;
            end
        end
    end

    assign cmd        = cmd_r;
    assign send_cmd   = send_cmd_r;
    assign clr_rx_rdy = clr_rx_rdy_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign err_code   = err_code_r;
    assign n_done     = n_done_r;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: vector table, randomized playbacks
// against a queue-based model, and directed timeout/abort/reset sequences.
module tb_cmd_sequencer;

    localparam int DEPTH = 8;
    localparam int TMO_W = 8;
    localparam int NW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push = 1'b0;
    logic [15:0]   push_cmd = 16'h0000;
    logic          full;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [15:0]   cmd;
    logic          send_cmd;
    logic          cmd_sent = 1'b0;
    logic          resp_rdy = 1'b0;
    logic [7:0]    resp = 8'h00;
    logic          clr_rx_rdy;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [NW-1:0] n_done;

    int nchk = 0;
    int nerr = 0;
    logic [15:0] mq[$];

    always #5 clk = ~clk;

    cmd_sequencer #(.DEPTH(DEPTH), .TMO_W(TMO_W), .RESP_OK(8'hA5)) dut (
        .clk(clk), .rst(rst), .push(push), .push_cmd(push_cmd), .full(full),
        .start(start), .abort(abort), .cmd(cmd), .send_cmd(send_cmd),
        .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
        .clr_rx_rdy(clr_rx_rdy), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .n_done(n_done)
    );

    typedef struct {
        int          npush;
        int          n;
        int          bad;
        int          ds;
        int          dr;
        logic [15:0] base;
        logic [15:0] step;
        int          exp_nd;
        logic        exp_err;
        logic [1:0]  exp_code;
        int          exp_done;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        nchk++;
        nerr++;
        $display("FAIL %s: no response within cycle budget", name);
    endtask

    task automatic do_push(input logic [15:0] v);
        push = 1'b1;
        push_cmd = v;
        tick();
        push = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(v);
    endtask

    task automatic wait_send(input string name, output int k);
        k = 0;
        while (send_cmd !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        if (send_cmd !== 1'b1) bound_fail(name);
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_cmd"}, cmd, 0);
        chk({p, "_send"}, send_cmd, 0);
        chk({p, "_clr"}, clr_rx_rdy, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_err"}, err, 0);
        chk({p, "_code"}, err_code, 0);
        chk({p, "_ndone"}, n_done, 0);
        chk({p, "_full"}, full, 0);
    endtask

    // Emulates RemoteComm for one playback of up to n commands.
    task automatic play(input int n, input int bad, input int ds, input int dr,
                        output int sends, output int clrs, output int done_cnt,
                        output int lat0, output int lat1);
        int k;
        logic [15:0] expv;
        sends = 0; clrs = 0; done_cnt = 0; lat0 = -1; lat1 = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            wait_send("send_wait", k);
            if (send_cmd !== 1'b1) break;
            if (i == 0) lat0 = k + 1;
            if (i == 1) lat1 = k;
            sends++;
            if (mq.size() > 0) begin
                expv = mq.pop_front();
                chk("cmd_value", cmd, expv);
            end else begin
                bound_fail("model_underflow");
            end
            tick();
            chk("send_one_cycle", send_cmd, 0);
            repeat (ds) tick();
            cmd_sent = 1'b1;
            tick();
            cmd_sent = 1'b0;
            repeat (dr) tick();
            resp = (i == bad) ? 8'h5A : 8'hA5;
            resp_rdy = 1'b1;
            tick();
            if (clr_rx_rdy === 1'b1) clrs++;
            resp_rdy = 1'b0;
            if (i == bad) break;
        end
        k = 0;
        while (busy === 1'b1 && k < 20) begin
            if (done === 1'b1) done_cnt++;
            tick();
            k++;
        end
        if (done === 1'b1) done_cnt++;
        if (busy !== 1'b0) bound_fail("busy_drain");
    endtask

    task automatic run_case(input vec_t v, input string tag);
        int sends, clrs, done_cnt, lat0, lat1, exp_sends;
        logic [15:0] c;
        c = v.base;
        for (int i = 0; i < v.npush; i++) begin
            do_push(c);
            chk({tag, "_full"}, full, (mq.size() == DEPTH) ? 1 : 0);
            c = c + v.step;
        end
        exp_sends = (v.bad < v.n) ? v.bad + 1 : v.n;
        play(v.n, v.bad, v.ds, v.dr, sends, clrs, done_cnt, lat0, lat1);
        chk({tag, "_sends"}, sends, exp_sends);
        chk({tag, "_clrs"}, clrs, exp_sends);
        chk({tag, "_done_pulses"}, done_cnt, v.exp_done);
        chk({tag, "_ndone"}, n_done, v.exp_nd);
        chk({tag, "_err"}, err, v.exp_err);
        chk({tag, "_code"}, err_code, v.exp_code);
        chk({tag, "_start_lat"}, lat0, 2);
        if (v.n >= 2 && v.bad >= 1) chk({tag, "_check_lat"}, lat1, 2);
        if (v.exp_err) mq.delete();
        tick();
        chk({tag, "_done_low"}, done, 0);
        // A start with an empty FIFO must answer with an immediate done.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_empty_done"}, done, 1);
        chk({tag, "_empty_busy"}, busy, 0);
        chk({tag, "_empty_ndone"}, n_done, 0);
        tick();
        chk({tag, "_empty_done_low"}, done, 0);
    endtask

    initial begin
        vec_t vt[6];
        vec_t rv;
        int k;
        int strobes;

        vt[0] = '{2, 2, 99, 3, 2, 16'h2000, 16'h2001, 2, 1'b0, 2'b00, 1};
        vt[1] = '{1, 1, 0,  1, 1, 16'h3333, 16'h0001, 0, 1'b1, 2'b10, 0};
        vt[2] = '{4, 4, 2,  0, 0, 16'hF000, 16'h0101, 2, 1'b1, 2'b10, 0};
        vt[3] = '{3, 3, 99, 0, 5, 16'h0001, 16'h1111, 3, 1'b0, 2'b00, 1};
        vt[4] = '{8, 8, 7,  2, 1, 16'hAAAA, 16'h0003, 7, 1'b1, 2'b10, 0};
        vt[5] = '{9, 8, 99, 1, 1, 16'h1000, 16'h0001, 8, 1'b0, 2'b00, 1};

        rst = 1'b1;
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_case(vt[i], $sformatf("vec%0d", i));
        end

        for (int r = 0; r < 12; r++) begin
            rv.n     = $urandom_range(1, DEPTH);
            rv.npush = rv.n;
            rv.bad   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rv.n - 1) : 99;
            rv.ds    = $urandom_range(0, 4);
            rv.dr    = $urandom_range(0, 4);
            rv.base  = 16'($urandom);
            rv.step  = 16'($urandom);
            rv.exp_err  = (rv.bad < rv.n);
            rv.exp_nd   = rv.exp_err ? rv.bad : rv.n;
            rv.exp_code = rv.exp_err ? 2'b10 : 2'b00;
            rv.exp_done = rv.exp_err ? 0 : 1;
            run_case(rv, $sformatf("rnd%0d", r));
        end

        // Timeout: cmd_sent never arrives.
        do_push(16'hBEEF);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_send("tmo_send_wait", k);
        void'(mq.pop_front());
        k = 0;
        while (err !== 1'b1 && k < 400) begin
            tick();
            k++;
        end
        chk("tmo_cycles", k, 256);
        chk("tmo_code", err_code, 2'b01);
        chk("tmo_busy_in_err", busy, 1);
        tick();
        chk("tmo_busy_falls", busy, 0);
        chk("tmo_err_sticky", err, 1);
        mq.delete();

        // Abort in the same cycle as a good response.
        do_push(16'h1234);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_err_cleared", err, 0);
        wait_send("abort_send_wait", k);
        chk("abort_cmd", cmd, 16'h1234);
        tick();
        cmd_sent = 1'b1;
        tick();
        cmd_sent = 1'b0;
        resp = 8'hA5;
        resp_rdy = 1'b1;
        abort = 1'b1;
        tick();
        resp_rdy = 1'b0;
        abort = 1'b0;
        chk("abort_err", err, 1);
        chk("abort_code", err_code, 2'b11);
        chk("abort_no_clr", clr_rx_rdy, 0);
        chk("abort_ndone", n_done, 0);
        tick();
        chk("abort_busy_falls", busy, 0);
        mq.delete();

        // Reset while waiting for the response.
        do_push(16'h5555);
        do_push(16'h6666);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_send("rst_send_wait", k);
        tick();
        cmd_sent = 1'b1;
        tick();
        cmd_sent = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("midrst");
        mq.delete();
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (send_cmd !== 1'b0 || clr_rx_rdy !== 1'b0 || busy !== 1'b0) strobes++;
        end
        chk("midrst_quiet", strobes, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("midrst_empty_done", done, 1);
        chk("midrst_empty_busy", busy, 0);
        tick();
        chk("midrst_done_low", done, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

- Synthesizable command player that sits directly upstream of RemoteComm, the BLE command sender feeding KnightsTour.
- Buffers up to DEPTH 16-bit commands and issues them one at a time over RemoteComm's send_cmd/cmd_sent handshake.
- After each command, waits for the acknowledge byte, checks it against RESP_OK, then clears it.
- Aborts on timeout, bad response or external abort, and reports the cause.

## Interface
- DEPTH, 8: command FIFO depth; power of two, ≥2.
- TMO_W, 24: timeout counter width; a wait times out when the counter reaches all-ones.
- RESP_OK, 8'hA5: expected acknowledge byte.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- push  in  1  write push_cmd into the FIFO.
- push_cmd  in  16  command word to queue.
- full  out  1  FIFO full.
- start  in  1  begin playing the queued commands.
- abort  in  1  stop immediately.
- cmd  out  16  command presented to RemoteComm.
- send_cmd  out  1  one-cycle send strobe.
- cmd_sent  in  1  RemoteComm finished transmitting.
- resp_rdy  in  1  response byte valid.
- resp  in  8  response byte.
- clr_rx_rdy  out  1  one-cycle clear of resp_rdy.
- busy  out  1  sequencer active.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error flag.
- err_code  out  2  error cause: 01 timeout, 10 bad response, 11 abort, 00 none.
- n_done  out  $clog2(DEPTH)+1  commands acknowledged since the last start.

## Operation
- FIFO: circular buffer with wptr/rptr and a count.
  - push while full is dropped and the FIFO is unchanged.
  - push is accepted in every state, so appending during playback is allowed.
  - Simultaneous push and pop leave count unchanged.
- IDLE:
  - start with FIFO non-empty → LOAD; clear err, err_code and n_done.
  - start with FIFO empty → pulse done next cycle and stay in IDLE; n_done = 0.
- LOAD: pop the head into the cmd register → SEND.
- SEND: assert send_cmd for exactly one cycle → WAIT_SENT.
- WAIT_SENT: wait for cmd_sent → WAIT_RESP; timeout → ERR (01).
- WAIT_RESP: wait for resp_rdy → CHECK; timeout → ERR (01).
- CHECK: assert clr_rx_rdy for one cycle.
  - resp == RESP_OK: increment n_done; FIFO non-empty → LOAD, else → FINISH.
  - Any other value → ERR (10).
- FINISH: pulse done → IDLE.
- ERR: set err and err_code, flush the FIFO (rptr = wptr, count = 0) → IDLE.
- abort in any non-IDLE state → ERR (11) next cycle; abort in IDLE is ignored.
- Simultaneous events: abort beats timeout and beats resp_rdy in the same cycle. A start while not IDLE is ignored.
- Timeout counter clears on every state entry and increments only in WAIT_SENT and WAIT_RESP.

## Timing
- Reset values: state IDLE, FIFO empty, cmd 16'h0000, and send_cmd, clr_rx_rdy, busy, done, err, full = 0; err_code 00; n_done 0.
- Reset takes effect at the next clk edge from any state, including mid-handshake. No strobe is emitted afterwards.
- All outputs are registered.
  - start → send_cmd: 2 cycles (LOAD, then SEND).
  - resp_rdy → clr_rx_rdy: 1 cycle.
  - CHECK → next send_cmd: 2 cycles.
- cmd is stable from LOAD until the next LOAD.
- busy = 1 in every state except IDLE.
- done is high for exactly one cycle, the cycle after FINISH.
- The timeout limit is 2^TMO_W − 1 cycles per wait.

## Structure
- Shared package seq_pkg holds:
  - state enum seq_state_t;
  - err_code localparams ERR_NONE/TMO/RESP/ABORT;
  - RESP_OK default.
- One sub-module, cmd_fifo (parameterised by DEPTH and width 16, with push/pop/full/empty/count), instantiated once.
- FSM, timeout counter and n_done live in the top.

## Test plan
- Queue 16'h2000, 16'h4001; start; bench model drives cmd_sent and then resp = 8'hA5 for each.
  - Expect cmd sequence 2000 then 4001, two send_cmd pulses and two clr_rx_rdy pulses.
  - Expect done pulse, n_done = 2, err = 0.
- Single command answered with resp = 8'h5A → err = 1, err_code = 10, FIFO flushed, n_done = 0, no done pulse.
- TMO_W = 8; cmd_sent never arrives → ERR at 255 cycles after entering WAIT_SENT, err_code = 01, busy falls.
- Push 9 commands with DEPTH = 8 → full after the 8th, 9th dropped; playback issues exactly 8 commands.
- abort asserted in the same cycle as resp_rdy = A5 → err_code = 11, n_done not incremented.
- rst asserted in WAIT_RESP → next cycle all outputs at reset values; a subsequent start with an empty FIFO gives an immediate done.
